// File: rtl/window_scheduler_pkg.sv
// Shared types and size helpers for the window scheduler and its per-axis counters.
package window_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } ws_state_e;

  localparam int FRAME_CNT_W = 16;

  function automatic int calc_out_w(input int row_size, input int kernel, input int stride);
    return (row_size - kernel) / stride + 1;
  endfunction

  function automatic int calc_out_h(input int column_size, input int kernel, input int stride);
    return (column_size - kernel) / stride + 1;
  endfunction

  // Index width that stays legal when a dimension collapses to a single entry.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stride_counter.sv
// One image axis: pixel position, stride phase and output-map index, all advanced
// incrementally so no divider is needed.
module stride_counter import window_scheduler_pkg::*; #(
  parameter  int SIZE        = 28,
  parameter  int KERNEL_SIZE = 3,
  parameter  int STRIDE      = 1,
  parameter  int OUT_N       = 26,
  localparam int PW          = idx_w(SIZE),
  localparam int IW          = idx_w(OUT_N)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr,
  input  logic          adv,
  output logic [PW-1:0] pos,
  output logic [IW-1:0] idx,
  output logic          qual
);

  localparam int PHW = idx_w(STRIDE);
  localparam logic [PW-1:0]  POS_LAST   = PW'(SIZE - 1);
  localparam logic [PW-1:0]  POS_ORIGIN = PW'(KERNEL_SIZE - 1);
  localparam logic [PHW-1:0] PH_LAST    = PHW'(STRIDE - 1);
  localparam logic [IW-1:0]  IDX_LAST   = IW'(OUT_N - 1);

  logic [PW-1:0]  pos_q, pos_d;
  logic [PHW-1:0] phase_q, phase_d;
  logic [IW-1:0]  idx_q, idx_d;

  assign pos  = pos_q;
  assign idx  = idx_q;
  assign qual = (pos_q >= POS_ORIGIN) && (phase_q == '0) && (idx_q <= IDX_LAST);

  always_comb begin
    pos_d   = pos_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    if (clr || (adv && pos_q == POS_LAST)) begin
      pos_d   = '0;
      phase_d = '0;
      idx_d   = '0;
    end else if (adv) begin
      pos_d = pos_q + 1'b1;
      // Phase only runs once the window's far edge is inside the row/column.
      if (pos_q >= POS_ORIGIN) begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          idx_d   = idx_q + 1'b1;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos_q   <= '0;
      phase_q <= '0;
      idx_q   <= '0;
    end else begin
      pos_q   <= pos_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/window_scheduler.sv
// Frame sequencer for a sliding-window buffer: gates pixel intake and flags each
// legal strided window with its output-map coordinates.
module window_scheduler import window_scheduler_pkg::*; #(
  parameter  int KERNEL_SIZE = 3,
  parameter  int DATA_SIZE   = 8,
  parameter  int ROW_SIZE    = 28,
  parameter  int COLUMN_SIZE = 28,
  parameter  int STRIDE      = 1,
  localparam int OUT_W       = calc_out_w(ROW_SIZE, KERNEL_SIZE, STRIDE),
  localparam int OUT_H       = calc_out_h(COLUMN_SIZE, KERNEL_SIZE, STRIDE),
  localparam int OWW         = idx_w(OUT_W),
  localparam int OHW         = idx_w(OUT_H)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   buf_valid,
  output logic                   window_valid,
  output logic [OHW-1:0]         out_row,
  output logic [OWW-1:0]         out_col,
  output logic                   window_last,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  if (DATA_SIZE < 1 || KERNEL_SIZE < 2 || STRIDE < 1 || STRIDE > KERNEL_SIZE) begin : g_bad_cfg
    $error("window_scheduler: illegal DATA_SIZE/KERNEL_SIZE/STRIDE combination");
  end

  localparam int PCW = idx_w(ROW_SIZE);
  localparam int PRW = idx_w(COLUMN_SIZE);
  localparam logic [PCW-1:0] COL_LAST      = PCW'(ROW_SIZE - 1);
  localparam logic [PRW-1:0] ROW_LAST      = PRW'(COLUMN_SIZE - 1);
  localparam logic [PRW-1:0] ROW_FILL_LAST = PRW'(KERNEL_SIZE - 2);
  localparam logic [OWW-1:0] OW_LAST       = OWW'(OUT_W - 1);
  localparam logic [OHW-1:0] OH_LAST       = OHW'(OUT_H - 1);

  ws_state_e              state_q, state_d;
  logic                   window_valid_q, window_valid_d;
  logic                   window_last_q, window_last_d;
  logic [OHW-1:0]         out_row_q, out_row_d;
  logic [OWW-1:0]         out_col_q, out_col_d;
  logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;

  logic           accept, start_frame, col_wrap, row_wrap, hit;
  logic [PCW-1:0] col_pos;
  logic [PRW-1:0] row_pos;
  logic [OWW-1:0] col_idx;
  logic [OHW-1:0] row_idx;
  logic           col_qual, row_qual;

  assign in_ready    = (state_q == ST_FILL) || (state_q == ST_STREAM);
  assign accept      = in_valid && in_ready;
  assign buf_valid   = accept;
  assign start_frame = (state_q == ST_IDLE) && start;
  assign col_wrap    = (col_pos == COL_LAST);
  assign row_wrap    = (row_pos == ROW_LAST);
  assign hit         = accept && col_qual && row_qual;

  stride_counter #(
    .SIZE(ROW_SIZE), .KERNEL_SIZE(KERNEL_SIZE), .STRIDE(STRIDE), .OUT_N(OUT_W)
  ) u_col (
    .clock(clock), .reset(reset), .clr(start_frame), .adv(accept),
    .pos(col_pos), .idx(col_idx), .qual(col_qual)
  );

  stride_counter #(
    .SIZE(COLUMN_SIZE), .KERNEL_SIZE(KERNEL_SIZE), .STRIDE(STRIDE), .OUT_N(OUT_H)
  ) u_row (
    .clock(clock), .reset(reset), .clr(start_frame), .adv(accept && col_wrap),
    .pos(row_pos), .idx(row_idx), .qual(row_qual)
  );

  always_comb begin
    state_d        = state_q;
    frame_count_d  = frame_count_q;
    window_valid_d = hit;
    window_last_d  = hit && (row_idx == OH_LAST) && (col_idx == OW_LAST);
    out_row_d      = hit ? row_idx : out_row_q;
    out_col_d      = hit ? col_idx : out_col_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_FILL;
      ST_FILL:   if (accept && col_wrap && row_pos == ROW_FILL_LAST) state_d = ST_STREAM;
      ST_STREAM: if (accept && col_wrap && row_wrap) begin
        state_d       = ST_DONE;
        frame_count_d = frame_count_q + 1'b1;
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      window_valid_q <= 1'b0;
      window_last_q  <= 1'b0;
      out_row_q      <= '0;
      out_col_q      <= '0;
      frame_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      window_valid_q <= window_valid_d;
      window_last_q  <= window_last_d;
      out_row_q      <= out_row_d;
      out_col_q      <= out_col_d;
      frame_count_q  <= frame_count_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign frame_done   = (state_q == ST_DONE);
  assign window_valid = window_valid_q;
  assign window_last  = window_last_q;
  assign out_row      = out_row_q;
  assign out_col      = out_col_q;
  assign frame_count  = frame_count_q;

endmodule
